flow_reshaper: RTL and testbench

- Frame-reshaping engine: reads one 320x240 RGB565 frame (76800 x 16-bit words) from a synchronous source RAM and writes it out as three planar 8-bit channel images (R plane, then G plane, then B plane) into a byte-wide destination memory.
- Sits between a camera frame buffer and a CHW-ordered accelerator input buffer.
- A pulse on ena starts one frame conversion.

---
 rtl/flow_reshaper_pkg.sv | 21 ++
 rtl/flow_reshaper_rgb565_expand.sv | 22 ++
 rtl/flow_reshaper.sv | 139 +++++++++++++
 tb/tb_flow_reshaper.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_reshaper_pkg.sv
// Shared constants and enumerations for the RGB565 -> planar CHW reshaper.
package flow_reshaper_pkg;

    localparam int IMG_W  = 320;
    localparam int IMG_H  = 240;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int ADDR_W = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } channel_e;

endpackage

// File: rtl/flow_reshaper_rgb565_expand.sv
// Picks one colour field out of an RGB565 pixel and widens it to 8 bits
// by replicating its top bits into the vacated LSBs (full-scale maps to 0xFF).
module rgb565_expand
    import flow_reshaper_pkg::*;
(
    input  logic [15:0] pixel,
    input  channel_e    ch,
    output logic [7:0]  chan_byte
);

    // Field select plus MSB replication.
    always_comb begin
        chan_byte = 8'h00;
        case (ch)
            CH_R:    chan_byte = {pixel[15:11], pixel[15:13]};
            CH_G:    chan_byte = {pixel[10:5],  pixel[10:9]};
            CH_B:    chan_byte = {pixel[4:0],   pixel[4:2]};
            default: chan_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/flow_reshaper.sv
// Reads a whole RGB565 frame three times (once per channel) and streams the
// extracted channel bytes out as contiguous R, G and B planes.
module flow_reshaper
    import flow_reshaper_pkg::*;
#(
    parameter int FRAME_W = IMG_W,
    parameter int FRAME_H = IMG_H,
    parameter int AW      = ADDR_W
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ena,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [15:0]   rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data
);

    localparam logic [AW-1:0] LAST_PIX = AW'(FRAME_W * FRAME_H - 1);

    // Read side: pix_reg doubles as the registered read address, out_idx_reg
    // is the matching plane-linear destination index (ch*NPIX + pix).
    state_e        state_reg,   state_next;
    channel_e      ch_reg,      ch_next;
    logic [AW-1:0] pix_reg,     pix_next;
    logic [AW-1:0] out_idx_reg, out_idx_next;
    logic          rd_en_reg,   rd_en_next;
    logic          drain_reg,   drain_next;

    // Write side: one stage aligned with rd_data, one stage for the byte.
    logic          wr_en_reg;
    logic [AW-1:0] wr_addr_reg;
    channel_e      ch_d_reg;
    logic [7:0]    wr_data_reg;
    logic [7:0]    expanded;

    rgb565_expand u_expand (
        .pixel     (rd_data),
        .ch        (ch_d_reg),
        .chan_byte (expanded)
    );

    // Control state, counters and read strobe registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            ch_reg      <= CH_R;
            pix_reg     <= '0;
            out_idx_reg <= '0;
            rd_en_reg   <= 1'b0;
            drain_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ch_reg      <= ch_next;
            pix_reg     <= pix_next;
            out_idx_reg <= out_idx_next;
            rd_en_reg   <= rd_en_next;
            drain_reg   <= drain_next;
        end
    end

    // Next-state logic: sequence pix 0..NPIX-1 for each channel, then drain.
    always_comb begin
        state_next   = state_reg;
        ch_next      = ch_reg;
        pix_next     = pix_reg;
        out_idx_next = out_idx_reg;
        rd_en_next   = 1'b0;
        drain_next   = drain_reg;
        case (state_reg)
            IDLE: begin
                if (ena) begin
                    state_next   = READ;
                    ch_next      = CH_R;
                    pix_next     = '0;
                    out_idx_next = '0;
                    rd_en_next   = 1'b1;
                end
            end
            READ: begin
                if (pix_reg == LAST_PIX) begin
                    if (ch_reg == CH_B) begin
                        // Last read issued; leave addresses at their final value.
                        state_next = DRAIN;
                        drain_next = 1'b0;
                    end else begin
                        ch_next      = channel_e'(ch_reg + 2'd1);
                        pix_next     = '0;
                        out_idx_next = out_idx_reg + 1'b1;
                        rd_en_next   = 1'b1;
                    end
                end else begin
                    pix_next     = pix_reg + 1'b1;
                    out_idx_next = out_idx_reg + 1'b1;
                    rd_en_next   = 1'b1;
                end
            end
            DRAIN: begin
                // Two cycles: one for the RAM read, one for the byte register.
                drain_next = 1'b1;
                if (drain_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write pipeline: strobe/address/channel follow the read by one cycle,
    // the extracted byte one cycle after that.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            ch_d_reg    <= CH_R;
            wr_data_reg <= 8'h00;
        end else begin
            wr_en_reg <= rd_en_reg;
            if (rd_en_reg) begin
                wr_addr_reg <= out_idx_reg;
                ch_d_reg    <= ch_reg;
            end
            if (wr_en_reg) begin
                wr_data_reg <= expanded;
            end
        end
    end

    assign rd_en   = rd_en_reg;
    assign rd_addr = pix_reg;
    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_flow_reshaper.sv
// Directed bench for flow_reshaper on a reduced 16x4 frame so that several
// complete frames fit in a short run; plane boundaries scale with NPIX.
module tb_flow_reshaper;

    localparam int TW    = 16;
    localparam int TH    = 4;
    localparam int TN    = TW * TH;
    localparam int TOT   = 3 * TN;
    localparam int AW    = 20;
    localparam int LIMIT = TOT + 50;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          ena = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data = 16'h0000;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    int nchecks = 0;
    int nerr    = 0;

    logic [15:0] mem [0:TN-1];
    logic [7:0]  dst [0:TOT-1];

    // Monitor statistics, reset whenever frame_id changes.
    int frame_id = 0;
    int seen_id  = 0;
    int rd_cnt, rd_ord_err, wr_cnt, wr_ord_err;
    int last_wr_addr;
    logic          pend = 1'b0;
    logic [AW-1:0] pend_addr;

    flow_reshaper #(.FRAME_W(TW), .FRAME_H(TH), .AW(AW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .ena     (ena),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    // Registered source RAM: data valid one cycle after rd_en/rd_addr.
    always @(posedge clk) begin
        if (rd_en && rd_addr < AW'(TN)) rd_data <= mem[rd_addr];
    end

    // Sequence/capture monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (seen_id != frame_id) begin
            seen_id      = frame_id;
            rd_cnt       = 0;
            rd_ord_err   = 0;
            wr_cnt       = 0;
            wr_ord_err   = 0;
            last_wr_addr = -1;
        end
        if (!rstn) begin
            pend = 1'b0;
        end else begin
            if (pend && pend_addr < AW'(TOT)) dst[pend_addr] = wr_data;
            if (rd_en) begin
                if (int'(rd_addr) != (rd_cnt % TN)) rd_ord_err++;
                rd_cnt++;
            end
            if (wr_en) begin
                if (int'(wr_addr) != wr_cnt) wr_ord_err++;
                wr_cnt++;
                last_wr_addr = int'(wr_addr);
            end
            pend      = wr_en;
            pend_addr = wr_addr;
        end
    end

    function automatic logic [7:0] ref_byte(input int idx);
        logic [15:0] p;
        int c;
        p = mem[idx % TN];
        c = idx / TN;
        case (c)
            0:       ref_byte = {p[15:11], p[15:13]};
            1:       ref_byte = {p[10:5],  p[10:9]};
            default: ref_byte = {p[4:0],   p[4:2]};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-18s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd_low(output int k);
        k = 0;
        while (rd_en === 1'b1 && k < LIMIT) begin
            step();
            k++;
        end
    endtask

    task automatic check_plane_data(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < TOT; i++) begin
            if (dst[i] !== ref_byte(i)) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < TN; i++) mem[i] = 16'(i);
        mem[0] = 16'hF800;
        mem[1] = 16'h07E0;
        mem[2] = 16'h001F;
        mem[3] = 16'h8410;

        // Reset state.
        step(); step();
        check("rst_rd_en",   rd_en,   0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_en",   wr_en,   0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        rstn = 1'b1;
        step();
        check("idle_rd_en", rd_en, 0);

        // Frame 1: ena held high for six cycles.
        frame_id++;
        ena = 1'b1;
        step();                                   // ena sampled here
        check("f1_first_rd_en",   rd_en,   1);
        check("f1_first_rd_addr", rd_addr, 0);
        check("f1_first_wr_en",   wr_en,   0);
        step();
        check("f1_first_wr_en1",  wr_en,   1);
        check("f1_first_wr_addr", wr_addr, 0);
        check("f1_rd_addr1",      rd_addr, 1);
        step();
        check("f1_wr_data0",      wr_data, 8'hFF);
        step(); step(); step();
        ena = 1'b0;
        k = 5;
        while (rd_en === 1'b1 && k < LIMIT) begin
            step();
            k++;
        end
        check("f1_read_cycles",   k,       TOT);
        check("f1_last_wr_en",    wr_en,   1);
        check("f1_last_wr_addr",  wr_addr, TOT - 1);
        step();
        check("f1_end_rd_en",     rd_en,   0);
        check("f1_end_wr_en",     wr_en,   0);
        repeat (10) step();
        check("f1_rd_count",      rd_cnt,     TOT);
        check("f1_rd_order",      rd_ord_err, 0);
        check("f1_wr_count",      wr_cnt,     TOT);
        check("f1_wr_order",      wr_ord_err, 0);
        check("f1_last_addr",     last_wr_addr, TOT - 1);
        check("f1_r_px0",         dst[0],          8'hFF);
        check("f1_g_px0",         dst[TN],         8'h00);
        check("f1_b_px0",         dst[2*TN],       8'h00);
        check("f1_r_px1",         dst[1],          8'h00);
        check("f1_g_px1",         dst[TN+1],       8'hFF);
        check("f1_b_px1",         dst[2*TN+1],     8'h00);
        check("f1_b_px2",         dst[2*TN+2],     8'hFF);
        check("f1_r_px3",         dst[3],          8'h84);
        check("f1_g_px3",         dst[TN+3],       8'h82);
        check("f1_b_px3",         dst[2*TN+3],     8'h84);
        check_plane_data("f1_all_bytes");

        // Frame 2: scrambled pixels, ena re-pulsed mid-frame (must be ignored).
        for (int i = 0; i < TN; i++) mem[i] = 16'((i * 40503) ^ (i << 11));
        frame_id++;
        ena = 1'b1;
        step();
        ena = 1'b0;
        repeat (20) step();
        ena = 1'b1;
        step();
        ena = 1'b0;
        wait_rd_low(k);
        check("f2_finished",      (k < LIMIT), 1);
        repeat (10) step();
        check("f2_rd_count",      rd_cnt,     TOT);
        check("f2_rd_order",      rd_ord_err, 0);
        check("f2_wr_count",      wr_cnt,     TOT);
        check("f2_wr_order",      wr_ord_err, 0);
        check("f2_r_edge",        dst[TN-1],   ref_byte(TN-1));
        check("f2_g_edge",        dst[TN],     ref_byte(TN));
        check("f2_g_edge2",       dst[2*TN-1], ref_byte(2*TN-1));
        check("f2_b_edge",        dst[2*TN],   ref_byte(2*TN));
        check_plane_data("f2_all_bytes");

        // Frame 3: aborted by reset mid-frame.
        frame_id++;
        ena = 1'b1;
        step();
        ena = 1'b0;
        repeat (20) step();
        rstn = 1'b0;
        #1;
        check("abort_rd_en",   rd_en,   0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_wr_en",   wr_en,   0);
        check("abort_wr_addr", wr_addr, 0);
        check("abort_wr_data", wr_data, 0);
        step(); step();
        rstn = 1'b1;
        repeat (5) step();
        check("abort_no_resume", rd_en, 0);

        // Frame 4: data[i] = i, fresh start after the abort.
        for (int i = 0; i < TN; i++) mem[i] = 16'(i);
        frame_id++;
        ena = 1'b1;
        step();
        ena = 1'b0;
        check("f4_first_rd_en",   rd_en,   1);
        check("f4_first_rd_addr", rd_addr, 0);
        step();
        check("f4_first_wr_en",   wr_en,   1);
        check("f4_first_wr_addr", wr_addr, 0);
        wait_rd_low(k);
        check("f4_finished",      (k < LIMIT), 1);
        repeat (10) step();
        check("f4_rd_count",      rd_cnt,     TOT);
        check("f4_rd_order",      rd_ord_err, 0);
        check("f4_wr_count",      wr_cnt,     TOT);
        check("f4_wr_order",      wr_ord_err, 0);
        check("f4_r_edge",        dst[TN-1],   ref_byte(TN-1));
        check("f4_g_edge",        dst[TN],     ref_byte(TN));
        check("f4_g_edge2",       dst[2*TN-1], ref_byte(2*TN-1));
        check("f4_b_edge",        dst[2*TN],   ref_byte(2*TN));
        check_plane_data("f4_all_bytes");

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
